// File: rtl/ahfp_cordic_pkg.sv
// Shared constants for the ahfp_cordic family: angle/gain tables, FSM encoding, float field layout.
package ahfp_cordic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_ITER  = 3'd2,
    ST_SCALE = 3'd3,
    ST_PACK  = 3'd4,
    ST_DONE  = 3'd5
  } cordic_state_e;

  localparam int F32_MAN_W = 23;
  localparam int F32_BIAS  = 127;
  localparam logic [7:0] F32_ERR_EXP = 8'd132;

  // Constants are kept in Q.30 and rounded down to the datapath precision (FRAC <= 29).
  localparam int          TBL_FRAC = 30;
  localparam logic [63:0] K_TBL    = 64'd652032874;
  localparam logic [63:0] PI_TBL   = 64'd3373259426;

  function automatic logic [63:0] atan_tbl(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_tbl = 64'd843314856;
      5'd1:    atan_tbl = 64'd497837829;
      5'd2:    atan_tbl = 64'd263043836;
      5'd3:    atan_tbl = 64'd133525158;
      5'd4:    atan_tbl = 64'd67021686;
      5'd5:    atan_tbl = 64'd33543515;
      5'd6:    atan_tbl = 64'd16775850;
      5'd7:    atan_tbl = 64'd8388437;
      5'd8:    atan_tbl = 64'd4194282;
      5'd9:    atan_tbl = 64'd2097149;
      5'd10:   atan_tbl = 64'd1048576;
      // atan(2^-i) equals 2^-i to within half a Q.30 LSB from here on
      default: atan_tbl = 64'd1 << (5'd30 - idx);
    endcase
  endfunction

endpackage

// File: rtl/ahfp_fix2float.sv
// Signed W-bit fixed point with FRAC fractional bits -> IEEE-754 single, round toward zero.
module ahfp_fix2float
  import ahfp_cordic_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 24
) (
  input  logic signed [W-1:0] fix,
  output logic        [31:0]  flt
);
  localparam int PW = $clog2(W);

  logic [W-1:0]           abs_s;
  logic [W-1:0]           norm_s;
  logic [PW-1:0]          lead_s;
  logic [7:0]             exp_s;
  logic [F32_MAN_W-1:0]   man_s;

  // leading-one detect, normalise and truncate the mantissa
  always_comb begin
    abs_s  = fix[W-1] ? unsigned'(-fix) : unsigned'(fix);
    lead_s = '0;
    for (int k = 0; k < W; k++) begin
      lead_s = abs_s[k] ? PW'(k) : lead_s;
    end
    norm_s = abs_s << (PW'(W - 1) - lead_s);
    man_s  = F32_MAN_W'({norm_s, 23'd0} >> (W - 1));
    exp_s  = 8'(int'(lead_s) + F32_BIAS - FRAC);
    if (abs_s == '0) begin
      flt = 32'd0;
    end else begin
      flt = {fix[W-1], exp_s, man_s};
    end
  end

endmodule

// File: rtl/ahfp_cordic_vector.sv
// Vectoring CORDIC: IEEE-754 (x, y) -> magnitude and atan2(y, x), one micro-rotation per clock.
module ahfp_cordic_vector
  import ahfp_cordic_pkg::*;
#(
  parameter int ITER = 24,
  parameter int FRAC = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mag,
  output logic [31:0] angle,
  output logic        err
);
  localparam int W  = FRAC + 8;
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SH = TBL_FRAC - FRAC;
  localparam logic [63:0] RND = 64'd1 << (SH - 1);
  localparam logic signed [W-1:0] K_FIX  = $signed(W'((K_TBL + RND) >> SH));
  localparam logic signed [W-1:0] PI_FIX = $signed(W'((PI_TBL + RND) >> SH));

  cordic_state_e         state_r;
  logic [31:0]           xin_r, yin_r;
  logic signed [W-1:0]   x_r, y_r, z_r;
  logic [IW-1:0]         i_r;
  logic                  err_r, zero_r;

  logic signed [W-1:0]   xf_s, yf_s, x_nx_s, y_nx_s, z_nx_s, x_scl_s, atan_s;
  logic signed [2*W-1:0] xw_s, kw_s, prod_s;
  logic [31:0]           mag_s, ang_s;

  // Float -> Q(W-FRAC).FRAC, truncating toward zero; exp==0 flushes to zero.
  function automatic logic signed [W-1:0] to_fix(input logic [31:0] f);
    logic [W-1:0] m;
    logic [23:0]  man;
    int           sh;
    man = {1'b1, f[22:0]};
    sh  = int'(f[30:23]) - 150 + FRAC;
    if (f[30:23] == 8'd0) begin
      m = '0;
    end else if (sh >= 0) begin
      m = W'(man) << sh;
    end else if (sh > -24) begin
      m = W'(man >> (-sh));
    end else begin
      m = '0;
    end
    to_fix = f[31] ? -$signed(m) : $signed(m);
  endfunction

  // operand conversion, micro-rotation step and gain correction
  always_comb begin
    xf_s   = to_fix(xin_r);
    yf_s   = to_fix(yin_r);
    atan_s = $signed(W'((atan_tbl(5'(i_r)) + RND) >> SH));
    if (!y_r[W-1]) begin
      x_nx_s = x_r + (y_r >>> i_r);
      y_nx_s = y_r - (x_r >>> i_r);
      z_nx_s = z_r + atan_s;
    end else begin
      x_nx_s = x_r - (y_r >>> i_r);
      y_nx_s = y_r + (x_r >>> i_r);
      z_nx_s = z_r - atan_s;
    end
    xw_s    = {{W{x_r[W-1]}}, x_r};
    kw_s    = {{W{K_FIX[W-1]}}, K_FIX};
    prod_s  = xw_s * kw_s;
    x_scl_s = W'(prod_s >>> FRAC);
  end

  ahfp_fix2float #(.W(W), .FRAC(FRAC)) u_mag_pack (.fix(x_r), .flt(mag_s));
  ahfp_fix2float #(.W(W), .FRAC(FRAC)) u_ang_pack (.fix(z_r), .flt(ang_s));

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag       <= 32'd0;
      angle     <= 32'd0;
      err       <= 1'b0;
      xin_r     <= 32'd0;
      yin_r     <= 32'd0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      i_r       <= '0;
      err_r     <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            xin_r    <= x_in;
            yin_r    <= y_in;
            in_ready <= 1'b0;
            state_r  <= ST_CONV;
          end
        end
        ST_CONV: begin
          err_r  <= (xin_r[30:23] >= F32_ERR_EXP) || (yin_r[30:23] >= F32_ERR_EXP);
          // atan2(0,0) would otherwise collect the whole angle table
          zero_r <= (xf_s == '0) && (yf_s == '0);
          if (xf_s[W-1]) begin
            x_r <= -xf_s;
            y_r <= -yf_s;
            z_r <= yf_s[W-1] ? -PI_FIX : PI_FIX;
          end else begin
            x_r <= xf_s;
            y_r <= yf_s;
            z_r <= '0;
          end
          i_r     <= '0;
          state_r <= ST_ITER;
        end
        ST_ITER: begin
          x_r <= x_nx_s;
          y_r <= y_nx_s;
          z_r <= z_nx_s;
          if (i_r == IW'(ITER - 1)) begin
            state_r <= ST_SCALE;
          end else begin
            i_r <= i_r + IW'(1);
          end
        end
        ST_SCALE: begin
          x_r     <= x_scl_s;
          state_r <= ST_PACK;
        end
        ST_PACK: begin
          mag       <= err_r ? 32'd0 : mag_s;
          angle     <= (err_r || zero_r) ? 32'd0 : ang_s;
          err       <= err_r;
          out_valid <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahfp_cordic_vector.sv
// Self-checking bench for ahfp_cordic_vector: directed vectors, handshake corner cases, random operands.
module tb_ahfp_cordic_vector;
  localparam int  ITER = 24;
  localparam int  FRAC = 24;
  localparam real TOL  = 1.0 / 262144.0;
  localparam real PI   = 3.14159265358979;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] x_in, y_in, mag, angle;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  ahfp_cordic_vector #(.ITER(ITER), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .mag(mag), .angle(angle), .err(err)
  );

  task automatic check_val(input string tag, input real got, input real want, input real tol);
    n_checks++;
    if ((got - want) <= tol && (want - got) <= tol) n_pass++;
    else $display("FAIL %s: got %0.9f want %0.9f tol %0.3g", tag, got, want, tol);
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -m : m;
  endfunction

  // input as the block sees it: truncated toward zero to FRAC fractional bits
  function automatic real quant(input logic [31:0] b);
    return real'($rtoi(f2r(b) * (2.0 ** FRAC))) / (2.0 ** FRAC);
  endfunction

  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] ya,
                        input bit exact0, input bit exp_err, input real emag, input real eang,
                        input real tol, input int stall, input bit noise);
    int lat;
    @(negedge clk);
    check_val({tag, ".in_ready"}, real'(in_ready), 1.0, 0.0);
    x_in = xa; y_in = ya; in_valid = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      x_in = $urandom; y_in = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_val({tag, ".latency"}, real'(lat), real'(ITER + 3), 0.0);
    for (int c = 0; c <= stall; c++) begin
      check_val({tag, ".out_valid"}, real'(out_valid), 1.0, 0.0);
      check_val({tag, ".busy"}, real'(in_ready), 0.0, 0.0);
      check_val({tag, ".err"}, real'(err), exp_err ? 1.0 : 0.0, 0.0);
      if (exact0 || exp_err) begin
        check_val({tag, ".mag_bits"}, real'(mag), 0.0, 0.0);
        check_val({tag, ".ang_bits"}, real'(angle), 0.0, 0.0);
      end else begin
        check_val({tag, ".mag"}, f2r(mag), emag, tol);
        check_val({tag, ".angle"}, f2r(angle), eang, tol);
      end
      if (c < stall) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, ".released"}, real'(out_valid), 0.0, 0.0);
  endtask

  initial begin
    logic [31:0] rx, ry;
    real         qx, qy;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = 32'd0; y_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.in_ready", real'(in_ready), 1.0, 0.0);
    check_val("rst.out_valid", real'(out_valid), 0.0, 0.0);
    check_val("rst.mag", real'(mag), 0.0, 0.0);
    check_val("rst.angle", real'(angle), 0.0, 0.0);
    check_val("rst.err", real'(err), 0.0, 0.0);
    @(negedge clk); reset = 1'b0;

    run_op("d_x1",    32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1.0, 0.0, TOL, 0, 1'b0);
    run_op("d_45",    32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1.41421356, 0.78539816, TOL, 10, 1'b0);
    run_op("d_rot1",  32'h3F0A5140, 32'h3F576AA4, 1'b0, 1'b0, 1.0, 1.0, TOL, 0, 1'b1);
    run_op("d_m135",  32'hBF800000, 32'hBF800000, 1'b0, 1'b0, 1.41421356, -2.35619449, TOL, 0, 1'b0);
    run_op("d_pi",    32'hBF800000, 32'h00000000, 1'b0, 1'b0, 1.0, PI, TOL, 0, 1'b0);
    run_op("d_pi_n0", 32'hBF800000, 32'h80000000, 1'b0, 1'b0, 1.0, PI, TOL, 0, 1'b0);
    run_op("d_zero",  32'h00000000, 32'h00000000, 1'b1, 1'b0, 0.0, 0.0, 0.0, 0, 1'b0);
    run_op("d_inf",   32'h7F800000, 32'h00000000, 1'b0, 1'b1, 0.0, 0.0, 0.0, 0, 1'b0);
    run_op("d_32",    32'h42000000, 32'h00000000, 1'b0, 1'b1, 0.0, 0.0, 0.0, 0, 1'b0);
    run_op("d_nan_y", 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 0.0, 0.0, 0.0, 0, 1'b0);
    run_op("d_edge",  32'h41FFFFFF, 32'h00000000, 1'b0, 1'b0, f2r(32'h41FFFFFF), 0.0, 4.0 * TOL, 0, 1'b0);

    // abort an operation mid-iteration (i == 5) with the async reset
    @(negedge clk);
    x_in = 32'h3F800000; y_in = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #2;
    check_val("arst.in_ready", real'(in_ready), 1.0, 0.0);
    check_val("arst.out_valid", real'(out_valid), 0.0, 0.0);
    check_val("arst.mag", real'(mag), 0.0, 0.0);
    @(negedge clk); reset = 1'b0;
    run_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1.41421356, 0.78539816, TOL, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      rx = {1'($urandom), 8'($urandom_range(130, 126)), 23'($urandom)};
      ry = {1'($urandom), 8'($urandom_range(130, 126)), 23'($urandom)};
      qx = quant(rx);
      qy = quant(ry);
      run_op($sformatf("rnd%0d", n), rx, ry, 1'b0, 1'b0, $sqrt(qx * qx + qy * qy), $atan2(qy, qx),
             TOL, int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
